// File: rtl/dedicated_processor_counter_gen_if.sv
// Bundle of the control and result signals of dedicated_processor_counter_gen.
//   master : drives start/mode/limit/step/pause, observes out/busy/done/ovf
//   slave  : the counter itself
//   start  1      launch a run (honoured in IDLE or DONE)
//   mode   2      00 up, 01 down, 10 sum, 11 up
//   limit  WIDTH  terminal value, or N for the sum job
//   step   WIDTH  increment/decrement for up/down (0 behaves as 1)
//   pause  1      freezes a run in progress while high
//   out    WIDTH  registered count or accumulator
//   busy   1      run in progress
//   done   1      one-cycle completion pulse
//   ovf    1      sticky sum wrap flag
interface dedicated_processor_counter_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] step;
  logic             pause;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, mode, limit, step, pause,
    input  out, busy, done, ovf
  );

  modport slave (
    input  start, mode, limit, step, pause,
    output out, busy, done, ovf
  );
endinterface

// File: rtl/dedicated_processor_counter_gen.sv
// Programmable counter built as a small control FSM plus datapath.
// Each run counts up, counts down, or accumulates 1+2+..+N, with a
// programmable step, a pause input, a one-cycle done pulse and a sticky
// overflow flag for the sum job. With FREE_RUN=1 a finished run reloads
// itself from the latched settings, turning the block into a plain
// repeating counter.
// Ports:
//   clk  in  system clock, everything on the rising edge
//   rst  in  synchronous active-high reset, aborts any run
//   bus  slave modport of dedicated_processor_counter_gen_if
module dedicated_processor_counter_gen #(
  parameter int WIDTH    = 8,
  parameter bit FREE_RUN = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  dedicated_processor_counter_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_SUM  = 2'b10;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH-1:0] idx_inc;
  logic             load;
  logic [1:0]       load_mode;
  logic [WIDTH-1:0] load_limit;

  // State and datapath registers. Reset puts the block back in IDLE with a
  // cleared result, whatever it was doing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      mode_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update. A "load" starts a run, either from the
  // inputs (start) or from the latched settings (free-run reload); the
  // shared tail below sets the initial value and skips RUN for limit==0.
  // The edge that writes the final value also enters DONE, so done and
  // the final out appear together.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    limit_d    = limit_q;
    step_d     = step_q;
    ovf_d      = ovf_q;
    load       = 1'b0;
    load_mode  = mode_q;
    load_limit = limit_q;

    up_sum  = {1'b0, out_q} + {1'b0, step_q};
    acc_sum = {1'b0, out_q} + {1'b0, idx_q} + {1'b0, ONE};
    idx_inc = idx_q + ONE;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          load_mode  = bus.mode;
          load_limit = bus.limit;
          mode_d     = bus.mode;
          limit_d    = bus.limit;
          step_d     = (bus.step == '0) ? ONE : bus.step;
          ovf_d      = 1'b0;
        end
      end
      S_RUN: begin
        if (!bus.pause) begin
          if (mode_q == MODE_SUM) begin
            idx_d = idx_inc;
            out_d = acc_sum[WIDTH-1:0];
            ovf_d = ovf_q | acc_sum[WIDTH];
            if (idx_inc == limit_q) state_d = S_DONE;
          end else if (mode_q == MODE_DOWN) begin
            if (out_q <= step_q) begin
              out_d   = '0;
              state_d = S_DONE;
            end else begin
              out_d = out_q - step_q;
            end
          end else begin
            // up, and the reserved mode which behaves as up; the extra
            // sum bit keeps a wrap from looking like a small value
            if (up_sum >= {1'b0, limit_q}) begin
              out_d   = limit_q;
              state_d = S_DONE;
            end else begin
              out_d = up_sum[WIDTH-1:0];
            end
          end
        end
      end
      S_DONE: begin
        if (FREE_RUN) begin
          load = 1'b1;
        end else if (bus.start) begin
          load       = 1'b1;
          load_mode  = bus.mode;
          load_limit = bus.limit;
          mode_d     = bus.mode;
          limit_d    = bus.limit;
          step_d     = (bus.step == '0) ? ONE : bus.step;
          ovf_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_d   = (load_mode == MODE_DOWN) ? load_limit : '0;
      idx_d   = '0;
      state_d = (load_limit == '0) ? S_DONE : S_RUN;
    end
  end

  // Outputs come straight from registers or from a decode of the state,
  // so nothing on the input side reaches them combinationally.
  always_comb begin
    bus.out  = out_q;
    bus.ovf  = ovf_q;
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_dedicated_processor_counter_gen.sv
// Directed bench for dedicated_processor_counter_gen: one single-shot
// instance and one FREE_RUN instance sharing clock and reset. Inputs change
// on the falling edge, outputs are inspected on the falling edge after the
// rising edge that produced them.
module tb_dedicated_processor_counter_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checkCount = 0;
  int passCount  = 0;
  int expSeq[$];

  dedicated_processor_counter_gen_if #(.WIDTH(8)) busA ();
  dedicated_processor_counter_gen_if #(.WIDTH(8)) busF ();

  dedicated_processor_counter_gen #(.WIDTH(8), .FREE_RUN(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  dedicated_processor_counter_gen #(.WIDTH(8), .FREE_RUN(1'b1)) dutFr (
    .clk (clk),
    .rst (rst),
    .bus (busF)
  );

  // 10 time-unit clock period
  always #5 clk = ~clk;

  // Count a comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Advance through one rising edge and stop at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start on the single-shot instance for one edge with given settings.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] lim, input logic [7:0] stp);
    busA.mode  = m;
    busA.limit = lim;
    busA.step  = stp;
    busA.start = 1'b1;
    tick();
    busA.start = 1'b0;
  endtask

  // Walk a run edge by edge against expSeq; the last entry is the done cycle.
  task automatic checkRun(input string tag);
    for (int i = 0; i < expSeq.size(); i++) begin
      if (i > 0) tick();
      checkOutput({tag, " out"}, int'(busA.out), expSeq[i]);
      checkOutput({tag, " done"}, int'(busA.done), (i == expSeq.size() - 1) ? 1 : 0);
      checkOutput({tag, " busy"}, int'(busA.busy), (i == expSeq.size() - 1) ? 0 : 1);
    end
  endtask

  initial begin
    busA.start = 1'b0; busA.mode = 2'b00; busA.limit = 8'd0; busA.step = 8'd0; busA.pause = 1'b0;
    busF.start = 1'b0; busF.mode = 2'b00; busF.limit = 8'd0; busF.step = 8'd0; busF.pause = 1'b0;

    // T1: reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset out", int'(busA.out), 0);
    checkOutput("reset busy", int'(busA.busy), 0);
    checkOutput("reset done", int'(busA.done), 0);
    checkOutput("reset ovf", int'(busA.ovf), 0);
    checkOutput("reset fr out", int'(busF.out), 0);

    // T2: up to 10 by 1, then held in IDLE
    applyStimulus(2'b00, 8'd10, 8'd1);
    expSeq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    checkRun("up10");
    tick();
    checkOutput("up10 idle out", int'(busA.out), 10);
    checkOutput("up10 idle done", int'(busA.done), 0);
    checkOutput("up10 idle busy", int'(busA.busy), 0);
    tick();
    checkOutput("up10 hold out", int'(busA.out), 10);

    // T3: up by 3 clamps at limit, then restart from DONE into down by 2
    applyStimulus(2'b00, 8'd10, 8'd3);
    expSeq = '{0, 3, 6, 9, 10};
    checkRun("up10s3");
    applyStimulus(2'b01, 8'd5, 8'd2);
    expSeq = '{5, 3, 1, 0};
    checkRun("down5s2");
    tick();

    // T4: sum of 1..10, then 1..30 wrapping, then start clears ovf
    applyStimulus(2'b10, 8'd10, 8'd0);
    expSeq = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45, 55};
    checkRun("sum10");
    checkOutput("sum10 ovf", int'(busA.ovf), 0);
    tick();
    applyStimulus(2'b10, 8'd30, 8'd0);
    repeat (29) tick();
    checkOutput("sum30 pre done", int'(busA.done), 0);
    tick();
    checkOutput("sum30 out", int'(busA.out), 209);
    checkOutput("sum30 done", int'(busA.done), 1);
    checkOutput("sum30 ovf", int'(busA.ovf), 1);
    // reserved mode behaves as up, step 0 behaves as 1
    applyStimulus(2'b11, 8'd3, 8'd0);
    checkOutput("restart ovf clear", int'(busA.ovf), 0);
    expSeq = '{0, 1, 2, 3};
    checkRun("mode3");
    tick();

    // T5: pause freezes, start in RUN is ignored
    applyStimulus(2'b00, 8'd20, 8'd1);
    repeat (5) tick();
    checkOutput("pre pause out", int'(busA.out), 5);
    busA.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("paused out", int'(busA.out), 5);
      checkOutput("paused busy", int'(busA.busy), 1);
    end
    busA.pause = 1'b0;
    busA.start = 1'b1; busA.mode = 2'b01; busA.limit = 8'd3; busA.step = 8'd2;
    tick();
    busA.start = 1'b0;
    checkOutput("start in run out", int'(busA.out), 6);
    repeat (13) tick();
    checkOutput("paused run out19", int'(busA.out), 19);
    checkOutput("paused run not done", int'(busA.done), 0);
    tick();
    checkOutput("paused run out20", int'(busA.out), 20);
    checkOutput("paused run done", int'(busA.done), 1);
    tick();

    // reset mid-run aborts
    applyStimulus(2'b00, 8'd20, 8'd1);
    repeat (4) tick();
    checkOutput("pre abort out", int'(busA.out), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort out", int'(busA.out), 0);
    checkOutput("abort busy", int'(busA.busy), 0);
    checkOutput("abort done", int'(busA.done), 0);
    tick();
    checkOutput("abort idle busy", int'(busA.busy), 0);

    // limit 0 goes straight to DONE on the start edge
    applyStimulus(2'b00, 8'd0, 8'd1);
    expSeq = '{0};
    checkRun("limit0");
    tick();
    checkOutput("limit0 after done", int'(busA.done), 0);

    // T6: free-running instance repeats 0..9 with done on every 9
    busF.mode = 2'b00; busF.limit = 8'd9; busF.step = 8'd1; busF.start = 1'b1;
    tick();
    busF.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) tick();
      checkOutput("fr out", int'(busF.out), i % 10);
      checkOutput("fr done", int'(busF.done), (i % 10 == 9) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
